instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 113 +++++++++++
 tb/tb_instr_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Byte-stream instruction loader: packs little-endian bytes into words and
// emits one write pulse per word into instruction memory until last or full.
module instr_loader #(
  parameter int WORD_LEN = 32,
  parameter int MEM_SIZE = 64
) (
  input  logic                      i_CLK,
  input  logic                      i_START,
  input  logic                      i_LOAD_EN,
  input  logic                      i_BYTE_VALID,
  input  logic [7:0]                i_BYTE,
  input  logic                      i_LAST,
  output logic                      o_BYTE_READY,
  output logic                      o_WE,
  output logic [WORD_LEN-1:0]       o_WADDR,
  output logic [WORD_LEN-1:0]       o_WDATA,
  output logic [$clog2(MEM_SIZE):0] o_WORD_CNT,
  output logic                      o_DONE
);

  localparam int BYTES = WORD_LEN / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CW    = $clog2(MEM_SIZE) + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t              state_reg, state_next;
  logic [BCW-1:0]      byte_cnt_reg;
  logic [WORD_LEN-1:0] asm_reg;
  logic [WORD_LEN-1:0] asm_merged;
  logic                last_reg;
  logic [WORD_LEN-1:0] waddr_reg;
  logic [WORD_LEN-1:0] wdata_reg;
  logic [CW-1:0]       word_cnt_reg;
  logic                accept;
  logic                final_byte;
  logic                at_last_slot;

  assign accept       = i_BYTE_VALID && (state_reg == COLLECT);
  assign final_byte   = (byte_cnt_reg == BCW'(BYTES - 1));
  assign at_last_slot = (waddr_reg == WORD_LEN'((MEM_SIZE - 1) * 4));

  // Current word with the incoming byte dropped into its lane.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign asm_merged[8*gi +: 8] = (byte_cnt_reg == BCW'(gi)) ? i_BYTE : asm_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge i_CLK or negedge i_START) begin
    if (!i_START) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    o_BYTE_READY = 1'b0;
    o_WE         = 1'b0;
    o_DONE       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_LOAD_EN) state_next = COLLECT;
      end
      COLLECT: begin
        o_BYTE_READY = 1'b1;
        if (accept && (final_byte || i_LAST)) state_next = WRITE;
      end
      WRITE: begin
        o_WE       = 1'b1;
        state_next = (last_reg || at_last_slot) ? DONE : COLLECT;
      end
      DONE: begin
        o_DONE = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address/data are captured on the completing byte so they are valid
  // throughout WRITE and simply hold afterwards.
  always_ff @(posedge i_CLK or negedge i_START) begin
    if (!i_START) begin
      byte_cnt_reg <= '0;
      asm_reg      <= '0;
      last_reg     <= 1'b0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      word_cnt_reg <= '0;
    end else begin
      if (accept) begin
        asm_reg      <= asm_merged;
        byte_cnt_reg <= byte_cnt_reg + 1'b1;
        if (final_byte || i_LAST) begin
          wdata_reg <= asm_merged;
          waddr_reg <= WORD_LEN'(word_cnt_reg) << 2;
          last_reg  <= i_LAST;
        end
      end
      if (state_reg == WRITE) begin
        word_cnt_reg <= word_cnt_reg + 1'b1;
        byte_cnt_reg <= '0;
        asm_reg      <= '0;
        last_reg     <= 1'b0;
      end
    end
  end

  assign o_WADDR    = waddr_reg;
  assign o_WDATA    = wdata_reg;
  assign o_WORD_CNT = word_cnt_reg;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected writes are queued as bytes are
// driven and popped by a monitor whenever the loader pulses o_WE.
module tb_instr_loader;
  localparam int WORD_LEN = 32;
  localparam int MEM_SIZE = 64;

  logic                      i_CLK;
  logic                      i_START;
  logic                      i_LOAD_EN;
  logic                      i_BYTE_VALID;
  logic [7:0]                i_BYTE;
  logic                      i_LAST;
  logic                      o_BYTE_READY;
  logic                      o_WE;
  logic [WORD_LEN-1:0]       o_WADDR;
  logic [WORD_LEN-1:0]       o_WDATA;
  logic [$clog2(MEM_SIZE):0] o_WORD_CNT;
  logic                      o_DONE;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic prev_we = 1'b0;

  instr_loader #(.WORD_LEN(WORD_LEN), .MEM_SIZE(MEM_SIZE)) dut (
    .i_CLK(i_CLK), .i_START(i_START), .i_LOAD_EN(i_LOAD_EN),
    .i_BYTE_VALID(i_BYTE_VALID), .i_BYTE(i_BYTE), .i_LAST(i_LAST),
    .o_BYTE_READY(o_BYTE_READY), .o_WE(o_WE), .o_WADDR(o_WADDR),
    .o_WDATA(o_WDATA), .o_WORD_CNT(o_WORD_CNT), .o_DONE(o_DONE)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  // Monitor: every write pulse must match the head of the scoreboard.
  always @(negedge i_CLK) begin
    if (i_START && o_WE) begin
      logic [63:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h (no write expected)", o_WADDR, o_WDATA);
      end else begin
        e = exp_q.pop_front();
        if ({o_WADDR, o_WDATA} !== e) begin
          errors++;
          $display("FAIL write addr=%h data=%h expected addr=%h data=%h", o_WADDR, o_WDATA, e[63:32], e[31:0]);
        end else begin
          $display("write addr=%h data=%h ok", o_WADDR, o_WDATA);
        end
      end
      checks++;
      if (prev_we !== 1'b0) begin
        errors++;
        $display("FAIL we_pulse_width o_WE high on consecutive cycles, expected single-cycle pulse");
      end
    end
    prev_we = o_WE;
  end

  task automatic apply_reset();
    @(negedge i_CLK);
    i_START = 1'b0; i_LOAD_EN = 1'b0; i_BYTE_VALID = 1'b0; i_LAST = 1'b0; i_BYTE = 8'h00;
    @(negedge i_CLK);
    i_START = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    logic got;
    got = 1'b0;
    @(negedge i_CLK);
    i_BYTE_VALID = 1'b1; i_BYTE = b; i_LAST = l;
    for (int t = 0; t < 50; t++) begin
      if (o_BYTE_READY) begin got = 1'b1; break; end
      @(negedge i_CLK);
    end
    if (got) @(posedge i_CLK);
    else begin
      checks++; errors++;
      $display("FAIL accept_timeout byte=%h ready=%b expected ready=1 within 50 cycles", b, o_BYTE_READY);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int n, input logic last, input logic gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge i_CLK); i_BYTE_VALID = 1'b0;
        end
      end
      send_byte(w[8*k +: 8], last && (k == n - 1));
    end
  endtask

  task automatic bus_idle();
    @(negedge i_CLK);
    i_BYTE_VALID = 1'b0; i_LAST = 1'b0;
  endtask

  task automatic finish_test(input string name, input int cnt, input logic [31:0] addr);
    repeat (3) @(negedge i_CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending %0d writes missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (o_DONE !== 1'b1 || o_WORD_CNT !== 7'(cnt) || o_WADDR !== addr) begin
      errors++;
      $display("FAIL %s_final done=%b cnt=%0d addr=%h expected done=1 cnt=%0d addr=%h",
               name, o_DONE, o_WORD_CNT, o_WADDR, cnt, addr);
    end else $display("%s final done=1 cnt=%0d addr=%h ok", name, cnt, addr);
  endtask

  task automatic test_reset();
    i_START = 1'b0; i_LOAD_EN = 1'b0; i_BYTE_VALID = 1'b0; i_LAST = 1'b0; i_BYTE = 8'h00;
    #1;
    checks++;
    if ({o_WE, o_BYTE_READY, o_DONE} !== 3'b000 || o_WADDR !== '0 || o_WDATA !== '0 || o_WORD_CNT !== '0) begin
      errors++;
      $display("FAIL reset we=%b rdy=%b done=%b addr=%h data=%h cnt=%0d expected all zero",
               o_WE, o_BYTE_READY, o_DONE, o_WADDR, o_WDATA, o_WORD_CNT);
    end else $display("reset outputs zero ok");
    @(negedge i_CLK);
    i_START = 1'b1;
  endtask

  task automatic test_idle_ignore();
    apply_reset();
    @(negedge i_CLK);
    i_BYTE_VALID = 1'b1; i_BYTE = 8'h5A;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_CLK);
      checks++;
      if (o_BYTE_READY !== 1'b0 || o_WE !== 1'b0 || o_WORD_CNT !== '0) begin
        errors++;
        $display("FAIL idle_ignore cyc=%0d rdy=%b we=%b cnt=%0d expected 0/0/0", c, o_BYTE_READY, o_WE, o_WORD_CNT);
      end
    end
    $display("idle_ignore 10 cycles done");
    i_BYTE_VALID = 1'b0;
  endtask

  task automatic test_basic();
    apply_reset();
    i_LOAD_EN = 1'b1;
    exp_q.push_back({32'h0, 32'h00100013});
    exp_q.push_back({32'h4, 32'h00200093});
    send_word(32'h00100013, 4, 1'b0, 1'b0);
    send_word(32'h00200093, 4, 1'b1, 1'b0);
    bus_idle();
    finish_test("basic", 2, 32'h4);
    checks++;
    if (o_WDATA !== 32'h00200093) begin
      errors++;
      $display("FAIL basic_hold data=%h expected 00200093", o_WDATA);
    end
  endtask

  task automatic test_partial();
    apply_reset();
    i_LOAD_EN = 1'b1;
    exp_q.push_back({32'h0, 32'h0000BBAA});
    send_word(32'h0000BBAA, 2, 1'b1, 1'b0);
    bus_idle();
    finish_test("partial", 1, 32'h0);
  endtask

  task automatic test_full();
    logic [31:0] w;
    apply_reset();
    i_LOAD_EN = 1'b1;
    for (int i = 0; i < MEM_SIZE; i++) begin
      w = $urandom;
      exp_q.push_back({32'(i * 4), w});
      send_word(w, 4, 1'b0, 1'b0);
    end
    @(negedge i_CLK);
    i_BYTE_VALID = 1'b1; i_BYTE = 8'hEE;
    for (int c = 0; c < 4; c++) begin
      @(negedge i_CLK);
      checks++;
      if (o_BYTE_READY !== 1'b0) begin
        errors++;
        $display("FAIL full_extra byte %0d ready=%b expected 0", c, o_BYTE_READY);
      end
    end
    bus_idle();
    finish_test("full", MEM_SIZE, 32'((MEM_SIZE - 1) * 4));
  endtask

  task automatic test_gaps();
    logic [31:0] w;
    apply_reset();
    i_LOAD_EN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      exp_q.push_back({32'(i * 4), w});
      send_word(w, 4, i == 4, 1'b1);
      i_LOAD_EN = 1'b0;
    end
    bus_idle();
    finish_test("gaps", 5, 32'h10);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    i_LOAD_EN = 1'b1;
    exp_q.push_back({32'h0, 32'h12345678});
    send_word(32'h12345678, 4, 1'b0, 1'b0);
    send_word(32'h0000BEEF, 2, 1'b0, 1'b0);
    @(negedge i_CLK);
    #2 i_START = 1'b0;
    #1;
    checks++;
    if ({o_WE, o_BYTE_READY, o_DONE} !== 3'b000 || o_WADDR !== '0 || o_WDATA !== '0 || o_WORD_CNT !== '0) begin
      errors++;
      $display("FAIL reset_mid we=%b rdy=%b done=%b addr=%h data=%h cnt=%0d expected all zero",
               o_WE, o_BYTE_READY, o_DONE, o_WADDR, o_WDATA, o_WORD_CNT);
    end else $display("reset_mid outputs zero ok");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_pending %0d writes missing before reset, expected 0", exp_q.size());
      exp_q.delete();
    end
    i_BYTE_VALID = 1'b0; i_LAST = 1'b0;
    @(negedge i_CLK);
    i_START = 1'b1;
    exp_q.push_back({32'h0, 32'hCAFEF00D});
    send_word(32'hCAFEF00D, 4, 1'b1, 1'b0);
    bus_idle();
    finish_test("reset_mid", 1, 32'h0);
  endtask

  initial begin
    fork
      begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_idle_ignore();
    test_basic();
    test_partial();
    test_full();
    test_gaps();
    test_reset_mid();
    repeat (2) @(negedge i_CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
